// File: rtl/gol_frame_streamer_if.sv
// Row stream bus from the frame streamer to its sink.
//   row_data  : one row of cells, bit c = column c
//   row_idx   : index of the row on row_data
//   row_valid : row_data/row_idx valid
//   row_ready : sink accepts the row
//   row_last  : valid row is the bottom row of the frame
interface gol_frame_streamer_if #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned HEIGHT = 10
);
  localparam int unsigned IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [WIDTH-1:0] row_data;
  logic [IW-1:0]    row_idx;
  logic             row_valid;
  logic             row_ready;
  logic             row_last;

  modport master (
    output row_data,
    output row_idx,
    output row_valid,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_data,
    input  row_idx,
    input  row_valid,
    input  row_last,
    output row_ready
  );
endinterface

// File: rtl/gol_frame_streamer.sv
// Captures a Game of Life cell array on request and streams it out one row
// per valid/ready transfer, tracking per-frame population and frame count.
//   clk         : clock, rising edge
//   rst         : asynchronous active-low reset
//   cells       : live cell vector, cell (r,c) = bit r*WIDTH+c
//   snap        : capture request, honoured only when idle
//   busy        : frame being streamed or finalised
//   frame_done  : one-cycle pulse after the last row is accepted
//   pop_count   : live cells in the last completed frame
//   frame_count : completed frames since reset (wraps)
//   row         : row stream bus (master side)
module gol_frame_streamer #(
  parameter int unsigned WIDTH  = 10,
  parameter int unsigned HEIGHT = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH*HEIGHT-1:0]             cells,
  input  logic                                snap,
  output logic                                busy,
  output logic                                frame_done,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0]   pop_count,
  output logic [15:0]                         frame_count,
  gol_frame_streamer_if.master                row
);

  localparam int unsigned IW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned PW = $clog2(WIDTH*HEIGHT+1);
  localparam int unsigned NC = WIDTH*HEIGHT;
  localparam logic [IW-1:0] LAST_IDX = IW'(HEIGHT-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,    state_d;
  logic [NC-1:0]    snapshot_q, snapshot_d;
  logic [IW-1:0]    idx_q,      idx_d;
  logic [WIDTH-1:0] data_q,     data_d;
  logic             valid_q,    valid_d;
  logic             last_q,     last_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic [PW-1:0]    acc_q,      acc_d;
  logic [PW-1:0]    pop_q,      pop_d;
  logic [15:0]      fc_q,       fc_d;

  logic [IW-1:0]    next_idx;
  logic [PW-1:0]    row_pc;

  // Number of live cells in one row.
  function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      s = s + PW'(v[i]);
    end
    return s;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      snapshot_q <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_q      <= '0;
      pop_q      <= '0;
      fc_q       <= '0;
    end else begin
      state_q    <= state_d;
      snapshot_q <= snapshot_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
      pop_q      <= pop_d;
      fc_q       <= fc_d;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so every port is driven straight from a flop.
  always_comb begin
    state_d    = state_q;
    snapshot_d = snapshot_q;
    idx_d      = idx_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    acc_d      = acc_q;
    pop_d      = pop_q;
    fc_d       = fc_q;

    next_idx = IW'(idx_q + IW'(1));
    row_pc   = popcnt(data_q);

    case (state_q)
      S_IDLE: begin
        if (snap) begin
          // First row comes straight from cells, identical to the capture.
          snapshot_d = cells;
          idx_d      = '0;
          acc_d      = '0;
          data_d     = cells[WIDTH-1:0];
          valid_d    = 1'b1;
          last_d     = (HEIGHT == 1);
          busy_d     = 1'b1;
          state_d    = S_SEND;
        end
      end

      S_SEND: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        last_d  = last_q;
        if (row.row_ready) begin
          if (idx_q == LAST_IDX) begin
            pop_d   = acc_q + row_pc;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
            data_d  = '0;
            state_d = S_DONE;
          end else begin
            acc_d  = acc_q + row_pc;
            idx_d  = next_idx;
            data_d = snapshot_q[int'(next_idx)*WIDTH +: WIDTH];
            last_d = (next_idx == LAST_IDX);
          end
        end
      end

      S_DONE: begin
        fc_d    = fc_q + 16'd1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy          = busy_q;
  assign frame_done    = done_q;
  assign pop_count     = pop_q;
  assign frame_count   = fc_q;
  assign row.row_data  = data_q;
  assign row.row_idx   = idx_q;
  assign row.row_valid = valid_q;
  assign row.row_last  = last_q;

endmodule

// File: tb/tb_gol_frame_streamer.sv
module tb_gol_frame_streamer;

  logic         clk;
  logic         rst;
  logic [99:0]  cells;
  logic         snap;
  logic         busy;
  logic         frame_done;
  logic [6:0]   pop_count;
  logic [15:0]  frame_count;

  int checks = 0;
  int errors = 0;

  gol_frame_streamer_if #(.WIDTH(10), .HEIGHT(10)) row_if ();

  gol_frame_streamer #(.WIDTH(10), .HEIGHT(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .cells       (cells),
    .snap        (snap),
    .busy        (busy),
    .frame_done  (frame_done),
    .pop_count   (pop_count),
    .frame_count (frame_count),
    .row         (row_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},   32'(busy), 32'd0);
    check({tag, " valid"},  32'(row_if.row_valid), 32'd0);
    check({tag, " last"},   32'(row_if.row_last), 32'd0);
    check({tag, " done"},   32'(frame_done), 32'd0);
    check({tag, " idx"},    32'(row_if.row_idx), 32'd0);
    check({tag, " data"},   32'(row_if.row_data), 32'd0);
    check({tag, " pop"},    32'(pop_count), 32'd0);
    check({tag, " fcount"}, 32'(frame_count), 32'd0);
  endtask

  // One frame with optional stall on a row and optional snap/cell disturbance.
  // All steps happen on falling edges, away from the active edge.
  task automatic run_frame(input string tag, input logic [99:0] img,
                           input int stall_idx, input int stall_n, input int disturb_idx,
                           input logic [6:0] exp_pop, input logic [15:0] exp_fc);
    logic [9:0] exp_row;
    @(negedge clk);
    cells = img;
    snap  = 1'b1;
    @(negedge clk);
    snap  = 1'b0;
    for (int r = 0; r < 10; r++) begin
      exp_row = img[r*10 +: 10];
      if (r == stall_idx) begin
        row_if.row_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          check({tag, " stall idx"},   32'(row_if.row_idx), 32'(r));
          check({tag, " stall data"},  32'(row_if.row_data), 32'(exp_row));
          check({tag, " stall valid"}, 32'(row_if.row_valid), 32'd1);
          @(negedge clk);
        end
        row_if.row_ready = 1'b1;
      end
      if (r == disturb_idx) begin
        snap  = 1'b1;
        cells = '0;
      end
      check({tag, " valid"}, 32'(row_if.row_valid), 32'd1);
      check({tag, " idx"},   32'(row_if.row_idx), 32'(r));
      check({tag, " data"},  32'(row_if.row_data), 32'(exp_row));
      check({tag, " last"},  32'(row_if.row_last), (r == 9) ? 32'd1 : 32'd0);
      check({tag, " busy"},  32'(busy), 32'd1);
      check({tag, " done early"}, 32'(frame_done), 32'd0);
      @(negedge clk);
      snap = 1'b0;
    end
    check({tag, " done pulse"}, 32'(frame_done), 32'd1);
    check({tag, " done valid"}, 32'(row_if.row_valid), 32'd0);
    check({tag, " done busy"},  32'(busy), 32'd1);
    check({tag, " done last"},  32'(row_if.row_last), 32'd0);
    check({tag, " pop"},        32'(pop_count), 32'(exp_pop));
    @(negedge clk);
    check({tag, " idle done"},  32'(frame_done), 32'd0);
    check({tag, " idle busy"},  32'(busy), 32'd0);
    check({tag, " idle valid"}, 32'(row_if.row_valid), 32'd0);
    check({tag, " idle idx"},   32'(row_if.row_idx), 32'd0);
    check({tag, " fcount"},     32'(frame_count), 32'(exp_fc));
    @(negedge clk);
    check({tag, " no requeue"}, 32'(row_if.row_valid), 32'd0);
    check({tag, " no 2nd done"}, 32'(frame_done), 32'd0);
    check({tag, " pop hold"},   32'(pop_count), 32'(exp_pop));
  endtask

  logic [99:0] blinker;
  logic [99:0] full;

  initial begin
    blinker = '0;
    blinker[44] = 1'b1;
    blinker[45] = 1'b1;
    blinker[46] = 1'b1;
    full = '1;

    rst   = 1'b0;
    snap  = 1'b0;
    cells = '0;
    row_if.row_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post-reset valid", 32'(row_if.row_valid), 32'd0);
      check("post-reset busy",  32'(busy), 32'd0);
    end

    // Blinker, free-flowing sink
    run_frame("blinker", blinker, -1, 0, -1, 7'd3, 16'd1);

    // Backpressure on row 2 for three cycles
    run_frame("bp", blinker, 2, 3, -1, 7'd3, 16'd2);

    // Snap pulse and cell clear while row 3 is on the bus
    run_frame("iso", blinker, -1, 0, 3, 7'd3, 16'd3);

    // Reset in the middle of a frame
    @(negedge clk);
    cells = blinker;
    snap  = 1'b1;
    @(negedge clk);
    snap  = 1'b0;
    repeat (5) @(negedge clk);
    check("abort pre idx", 32'(row_if.row_idx), 32'd5);
    rst = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("abort no done",  32'(frame_done), 32'd0);
      check("abort no valid", 32'(row_if.row_valid), 32'd0);
      check("abort fcount",   32'(frame_count), 32'd0);
    end

    // Full frames after the aborted one
    run_frame("full1", full, -1, 0, -1, 7'd100, 16'd1);
    run_frame("full2", full, 5, 2, -1, 7'd100, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
